// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall and flush vectors,
// PC redirect on exceptions, post-exception shadow window, debug halt and stall watchdog.
module pipeline_ctrl #(
  parameter int unsigned     STAGES        = 6,
  parameter int unsigned     AW            = 32,
  parameter int unsigned     SHADOW_CYCLES = 1,
  parameter int unsigned     STALL_TIMEOUT = 1024,
  parameter logic [AW-1:0]   IDLE_PC       = AW'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              exc_valid_i,
  input  logic              exc_eret_i,
  input  logic              exc_refill_i,
  input  logic [AW-1:0]     cp0_epc_i,
  input  logic [AW-1:0]     cp0_ebase_i,
  input  logic              halt_req_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic              redirect_valid_o,
  output logic [AW-1:0]     redirect_pc_o,
  output logic              halt_ack_o,
  output logic              busy_o,
  output logic              stall_timeout_o
);

  typedef enum logic [1:0] {RUN, SHADOW, HALT} state_e;

  localparam int unsigned SW = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;
  localparam int unsigned CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [SW-1:0]     SHADOW_LOAD = (SHADOW_CYCLES > 0) ? SW'(SHADOW_CYCLES - 1) : '0;
  localparam logic [CW-1:0]     WD_MAX      = CW'(STALL_TIMEOUT);
  localparam logic [STAGES-1:0] FLUSH_ALL   = {{(STAGES-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0]     VEC_OFFSET  = AW'(32'h180);

  state_e          state_q, state_d;
  logic [SW-1:0]   shadowCnt_q, shadowCnt_d;
  logic [CW-1:0]   wdCnt_q, wdCnt_d;
  logic [STAGES-1:0] stallPrefix;
  logic            prefixAcc;
  logic            excEvent;

  assign excEvent = exc_refill_i | exc_valid_i;

  // A request at stage k holds every stage upstream of it as well.
  always_comb begin
    stallPrefix = '0;
    prefixAcc   = 1'b0;
    for (int j = int'(STAGES) - 1; j >= 0; j--) begin
      prefixAcc      = prefixAcc | stall_req_i[j];
      stallPrefix[j] = prefixAcc;
    end
  end

  always_comb begin
    state_d          = state_q;
    shadowCnt_d      = shadowCnt_q;
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = IDLE_PC;
    unique case (state_q)
      RUN: begin
        if (excEvent) begin
          flush_o          = FLUSH_ALL;
          redirect_valid_o = 1'b1;
          if (exc_refill_i)    redirect_pc_o = cp0_ebase_i;
          else if (exc_eret_i) redirect_pc_o = cp0_epc_i;
          else                 redirect_pc_o = cp0_ebase_i + VEC_OFFSET;
          if (SHADOW_CYCLES > 0) begin
            state_d     = SHADOW;
            shadowCnt_d = SHADOW_LOAD;
          end
        end else if (halt_req_i) begin
          stall_o = '1;
          state_d = HALT;
        end else begin
          stall_o = stallPrefix;
        end
      end
      SHADOW: begin
        flush_o = FLUSH_ALL;
        if (shadowCnt_q == '0) state_d = RUN;
        else                   shadowCnt_d = shadowCnt_q - 1'b1;
      end
      HALT: begin
        if (halt_req_i) begin
          stall_o = '1;
        end else begin
          stall_o = stallPrefix;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset forces a quiet pipeline even while requests are still asserted.
    if (rst) begin
      stall_o          = '0;
      flush_o          = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = IDLE_PC;
    end
  end

  always_comb begin
    wdCnt_d = '0;
    if (state_q == RUN && !excEvent && stall_o != '0) begin
      wdCnt_d = (wdCnt_q == WD_MAX) ? wdCnt_q : wdCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      shadowCnt_q <= '0;
      wdCnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      shadowCnt_q <= shadowCnt_d;
      wdCnt_q     <= wdCnt_d;
    end
  end

  assign busy_o          = !rst && (state_q != RUN);
  assign halt_ack_o      = !rst && (state_q == HALT);
  assign stall_timeout_o = (STALL_TIMEOUT != 0) && (wdCnt_q == WD_MAX);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: default instance plus a 3-cycle-shadow/4-cycle-watchdog
// instance and a watchdog-disabled instance, all sharing one stimulus set.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallReq;
  logic        excValid, excEret, excRefill, haltReq;
  logic [31:0] epc, ebase;

  logic [5:0]  aStall, aFlush, bStall, bFlush, cStall, cFlush;
  logic        aRv, aHaltAck, aBusy, aTimeout;
  logic        bRv, bHaltAck, bBusy, bTimeout;
  logic        cRv, cHaltAck, cBusy, cTimeout;
  logic [31:0] aPc, bPc, cPc;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dutA (
    .clk(clk), .rst(rst), .stall_req_i(stallReq), .exc_valid_i(excValid), .exc_eret_i(excEret),
    .exc_refill_i(excRefill), .cp0_epc_i(epc), .cp0_ebase_i(ebase), .halt_req_i(haltReq),
    .stall_o(aStall), .flush_o(aFlush), .redirect_valid_o(aRv), .redirect_pc_o(aPc),
    .halt_ack_o(aHaltAck), .busy_o(aBusy), .stall_timeout_o(aTimeout)
  );

  pipeline_ctrl #(.SHADOW_CYCLES(3), .STALL_TIMEOUT(4)) dutB (
    .clk(clk), .rst(rst), .stall_req_i(stallReq), .exc_valid_i(excValid), .exc_eret_i(excEret),
    .exc_refill_i(excRefill), .cp0_epc_i(epc), .cp0_ebase_i(ebase), .halt_req_i(haltReq),
    .stall_o(bStall), .flush_o(bFlush), .redirect_valid_o(bRv), .redirect_pc_o(bPc),
    .halt_ack_o(bHaltAck), .busy_o(bBusy), .stall_timeout_o(bTimeout)
  );

  pipeline_ctrl #(.STALL_TIMEOUT(0)) dutC (
    .clk(clk), .rst(rst), .stall_req_i(stallReq), .exc_valid_i(excValid), .exc_eret_i(excEret),
    .exc_refill_i(excRefill), .cp0_epc_i(epc), .cp0_ebase_i(ebase), .halt_req_i(haltReq),
    .stall_o(cStall), .flush_o(cFlush), .redirect_valid_o(cRv), .redirect_pc_o(cPc),
    .halt_ack_o(cHaltAck), .busy_o(cBusy), .stall_timeout_o(cTimeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stallReq = '0; excValid = 0; excEret = 0; excRefill = 0; haltReq = 0;
  endtask

  task automatic test_reset();
    rst = 1; stallReq = 6'b111111; excValid = 1; excEret = 0; excRefill = 0; haltReq = 0;
    epc = 32'h8000_0404; ebase = 32'h8000_1000;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      assertCount++; if (aStall !== 6'b0) begin failCount++; $display("[TB] FAIL reset_stall: got %b expected %b", aStall, 6'b0); end
      assertCount++; if (aFlush !== 6'b0) begin failCount++; $display("[TB] FAIL reset_flush: got %b expected %b", aFlush, 6'b0); end
      assertCount++; if (aRv !== 1'b0) begin failCount++; $display("[TB] FAIL reset_redirect_valid: got %b expected 0", aRv); end
      assertCount++; if (aPc !== 32'h8000_0000) begin failCount++; $display("[TB] FAIL reset_redirect_pc: got %h expected 80000000", aPc); end
      assertCount++; if (aBusy !== 1'b0 || aHaltAck !== 1'b0 || aTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL reset_status: busy=%b ack=%b timeout=%b expected 0 0 0", aBusy, aHaltAck, aTimeout); end
    end
    tick();
    rst = 0;
    clearInputs();
  endtask

  task automatic test_stall_prefix();
    stallReq = 6'b010000;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b011111) begin failCount++; $display("[TB] FAIL stall_k4: got %b expected %b", aStall, 6'b011111); end
    assertCount++; if (aFlush !== 6'b0) begin failCount++; $display("[TB] FAIL stall_k4_flush: got %b expected %b", aFlush, 6'b0); end
    tick();
    stallReq = 6'b000010;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b000011) begin failCount++; $display("[TB] FAIL stall_k1: got %b expected %b", aStall, 6'b000011); end
    assertCount++; if (aFlush !== 6'b0) begin failCount++; $display("[TB] FAIL stall_k1_flush: got %b expected %b", aFlush, 6'b0); end
    tick();
    stallReq = 6'b010100;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b011111) begin failCount++; $display("[TB] FAIL stall_multi: got %b expected %b", aStall, 6'b011111); end
    assertCount++; if (aPc !== 32'h8000_0000 || aRv !== 1'b0) begin failCount++; $display("[TB] FAIL stall_no_redirect: pc=%h rv=%b expected 80000000 0", aPc, aRv); end
    tick();
    stallReq = 6'b100000;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b111111) begin failCount++; $display("[TB] FAIL stall_k5: got %b expected %b", aStall, 6'b111111); end
    tick();
    stallReq = 6'b0;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b0) begin failCount++; $display("[TB] FAIL stall_none: got %b expected %b", aStall, 6'b0); end
    tick();
  endtask

  task automatic test_exception();
    excValid = 1;
    @(negedge clk);
    assertCount++; if (aRv !== 1'b1) begin failCount++; $display("[TB] FAIL exc_redirect_valid: got %b expected 1", aRv); end
    assertCount++; if (aPc !== 32'h8000_1180) begin failCount++; $display("[TB] FAIL exc_vector: got %h expected 80001180", aPc); end
    assertCount++; if (aFlush !== 6'b111110) begin failCount++; $display("[TB] FAIL exc_flush: got %b expected %b", aFlush, 6'b111110); end
    assertCount++; if (aBusy !== 1'b0) begin failCount++; $display("[TB] FAIL exc_busy: got %b expected 0", aBusy); end
    tick();
    @(negedge clk);
    assertCount++; if (aRv !== 1'b0 || aPc !== 32'h8000_0000) begin failCount++; $display("[TB] FAIL shadow_masks_exc: rv=%b pc=%h expected 0 80000000", aRv, aPc); end
    assertCount++; if (aFlush !== 6'b111110 || aBusy !== 1'b1) begin failCount++; $display("[TB] FAIL shadow_flush_busy: flush=%b busy=%b expected 111110 1", aFlush, aBusy); end
    tick();
    excValid = 0;
    @(negedge clk);
    assertCount++; if (aBusy !== 1'b0 || aFlush !== 6'b0) begin failCount++; $display("[TB] FAIL shadow_exit: busy=%b flush=%b expected 0 000000", aBusy, aFlush); end
    tick();
  endtask

  task automatic test_eret();
    excValid = 1; excEret = 1;
    @(negedge clk);
    assertCount++; if (aRv !== 1'b1 || aPc !== 32'h8000_0404) begin failCount++; $display("[TB] FAIL eret_target: rv=%b pc=%h expected 1 80000404", aRv, aPc); end
    tick();
    clearInputs();
    tick();
    tick();
  endtask

  task automatic test_refill();
    excValid = 1; excEret = 1; excRefill = 1; stallReq = 6'b111111;
    @(negedge clk);
    assertCount++; if (aPc !== 32'h8000_1000 || aRv !== 1'b1) begin failCount++; $display("[TB] FAIL refill_wins: rv=%b pc=%h expected 1 80001000", aRv, aPc); end
    assertCount++; if (aStall !== 6'b0) begin failCount++; $display("[TB] FAIL event_drops_stall: got %b expected %b", aStall, 6'b0); end
    tick();
    clearInputs();
    excRefill = 1;
    tick();
    @(negedge clk);
    assertCount++; if (aPc !== 32'h8000_1000 || aRv !== 1'b1) begin failCount++; $display("[TB] FAIL refill_alone: rv=%b pc=%h expected 1 80001000", aRv, aPc); end
    tick();
    clearInputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_shadow_length();
    stallReq = 6'b001000; excValid = 1;
    @(negedge clk);
    assertCount++; if (bStall !== 6'b0 || bBusy !== 1'b0) begin failCount++; $display("[TB] FAIL shadow3_event: stall=%b busy=%b expected 000000 0", bStall, bBusy); end
    tick();
    excValid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertCount++; if (bBusy !== 1'b1 || bStall !== 6'b0) begin failCount++; $display("[TB] FAIL shadow3_cycle%0d: busy=%b stall=%b expected 1 000000", i, bBusy, bStall); end
      tick();
    end
    @(negedge clk);
    assertCount++; if (bBusy !== 1'b0 || bStall !== 6'b001111) begin failCount++; $display("[TB] FAIL shadow3_exit: busy=%b stall=%b expected 0 001111", bBusy, bStall); end
    tick();
    stallReq = 6'b0;
    tick();
  endtask

  task automatic test_halt();
    haltReq = 1; stallReq = 6'b000100;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b111111 || aHaltAck !== 1'b0) begin failCount++; $display("[TB] FAIL halt_entry: stall=%b ack=%b expected 111111 0", aStall, aHaltAck); end
    tick();
    @(negedge clk);
    assertCount++; if (aHaltAck !== 1'b1 || aBusy !== 1'b1 || aStall !== 6'b111111) begin failCount++; $display("[TB] FAIL halt_held: ack=%b busy=%b stall=%b expected 1 1 111111", aHaltAck, aBusy, aStall); end
    tick();
    excValid = 1;
    @(negedge clk);
    assertCount++; if (aRv !== 1'b0 || aFlush !== 6'b0) begin failCount++; $display("[TB] FAIL halt_ignores_exc: rv=%b flush=%b expected 0 000000", aRv, aFlush); end
    tick();
    excValid = 0; haltReq = 0; stallReq = 6'b000010;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b000011 || aHaltAck !== 1'b1) begin failCount++; $display("[TB] FAIL halt_release: stall=%b ack=%b expected 000011 1", aStall, aHaltAck); end
    tick();
    @(negedge clk);
    assertCount++; if (aHaltAck !== 1'b0 || aBusy !== 1'b0 || aStall !== 6'b000011) begin failCount++; $display("[TB] FAIL halt_back_to_run: ack=%b busy=%b stall=%b expected 0 0 000011", aHaltAck, aBusy, aStall); end
    tick();
    haltReq = 1; stallReq = 6'b0;
    tick();
    haltReq = 0;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b0) begin failCount++; $display("[TB] FAIL halt_release_idle: got %b expected %b", aStall, 6'b0); end
    tick();
  endtask

  task automatic test_reset_midway();
    excValid = 1;
    tick();
    excValid = 0;
    @(negedge clk);
    assertCount++; if (bBusy !== 1'b1) begin failCount++; $display("[TB] FAIL midshadow_pre: busy=%b expected 1", bBusy); end
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    assertCount++; if (bBusy !== 1'b0) begin failCount++; $display("[TB] FAIL midshadow_reset: busy=%b expected 0", bBusy); end
    tick();
    haltReq = 1;
    tick();
    rst = 1;
    @(negedge clk);
    assertCount++; if (aStall !== 6'b0 || aHaltAck !== 1'b0) begin failCount++; $display("[TB] FAIL reset_quiets_halt: stall=%b ack=%b expected 000000 0", aStall, aHaltAck); end
    tick();
    rst = 0; haltReq = 0;
    @(negedge clk);
    assertCount++; if (aBusy !== 1'b0 || aHaltAck !== 1'b0) begin failCount++; $display("[TB] FAIL midhalt_reset: busy=%b ack=%b expected 0 0", aBusy, aHaltAck); end
    tick();
  endtask

  task automatic test_watchdog();
    stallReq = 6'b0;
    tick();
    stallReq = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      assertCount++; if (bTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL wd_early_cycle%0d: got %b expected 0", i + 1, bTimeout); end
      tick();
    end
    @(negedge clk);
    assertCount++; if (bTimeout !== 1'b1) begin failCount++; $display("[TB] FAIL wd_trip: got %b expected 1", bTimeout); end
    assertCount++; if (aTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL wd_default_quiet: got %b expected 0", aTimeout); end
    tick();
    @(negedge clk);
    assertCount++; if (bTimeout !== 1'b1) begin failCount++; $display("[TB] FAIL wd_saturate: got %b expected 1", bTimeout); end
    tick();
    stallReq = 6'b0;
    @(negedge clk);
    assertCount++; if (bTimeout !== 1'b1) begin failCount++; $display("[TB] FAIL wd_sticky: got %b expected 1", bTimeout); end
    tick();
    @(negedge clk);
    assertCount++; if (bTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL wd_clear: got %b expected 0", bTimeout); end
    assertCount++; if (cTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL wd_disabled: got %b expected 0", cTimeout); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stall_prefix();
    test_exception();
    test_eret();
    test_refill();
    test_shadow_length();
    test_halt();
    test_reset_midway();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Generalised pipeline hazard and exception controller for the MIPS32 core. It takes per-stage stall requests, exception, ERET and TLB-refill events, and a debug halt request. It produces per-stage stall and flush vectors, the PC redirect target, a post-exception shadow window, and a stall watchdog. It sits beside the pipeline registers, driven from ID/EXE/MEM, CP0 and the debug unit, and replaces the fixed six-stage controller.

Parameters:
STAGES, 6, number of pipeline registers incl. PC (bit 0 = PC, bit STAGES-1 = WB)
AW, 32, address width of epc/ebase/redirect
SHADOW_CYCLES, 1, cycles after an exception during which exceptions are masked and stage regs 1..STAGES-1 stay flushed (0 = no shadow)
STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout_o (0 = watchdog disabled)
IDLE_PC, 32'h80000000, redirect_pc_o value when no redirect

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stall_req_i  in  STAGES  stall request; bit k set stalls stages 0..k
exc_valid_i  in  1  exception committed in MEM this cycle
exc_eret_i  in  1  qualifies exc_valid_i: ERET
exc_refill_i  in  1  TLB refill; ranks above exc_valid_i
cp0_epc_i  in  AW  CP0 EPC
cp0_ebase_i  in  AW  CP0 EBase
halt_req_i  in  1  debug halt request (level)
stall_o  out  STAGES  per-stage hold
flush_o  out  STAGES  per-stage clear
redirect_valid_o  out  1  PC must load redirect_pc_o at next edge
redirect_pc_o  out  AW  redirect target
halt_ack_o  out  1  pipeline frozen for debug
busy_o  out  1  FSM not in RUN
stall_timeout_o  out  1  watchdog tripped (sticky until stall clears)

Behaviour:
- Interface fixed: one clock clk; reset rst is synchronous and active-high.
- Reset: FSM=RUN, shadow counter=0, stall counter=0. All outputs 0 except redirect_pc_o=IDLE_PC. A reset mid-shadow or mid-halt returns to RUN at the next edge.
- FSM states: RUN, SHADOW, HALT.
- Combinational priority in RUN: event > halt > stall > idle. Event = exc_refill_i | exc_valid_i.
- Event in RUN, same cycle (zero latency):
  - flush_o = all ones except bit 0; stall_o = 0; redirect_valid_o = 1.
  - redirect_pc_o: refill -> cp0_ebase_i; else ERET -> cp0_epc_i; else cp0_ebase_i + 0x180 (mod 2^AW).
  - Next state: SHADOW if SHADOW_CYCLES > 0 (counter loaded SHADOW_CYCLES-1), else RUN.
- SHADOW:
  - exc_valid_i, exc_refill_i, stall_req_i and halt_req_i are ignored.
  - flush_o = all ones except bit 0; stall_o = 0; redirect_valid_o = 0.
  - Counter decrements; at 0, go to RUN. busy_o = 1.
- Halt, RUN with halt_req_i=1 and no event: stall_o = all ones, go to HALT.
- HALT:
  - stall_o = all ones; halt_ack_o = 1; busy_o = 1.
  - Exceptions are ignored (pipeline frozen, none can commit).
  - halt_req_i=0 returns to RUN, with stall_o = 0 in that cycle unless a request is present.
- Stall, RUN with no event or halt:
  - k = highest set bit of stall_req_i; stall_o[j] = 1 for j ≤ k, else 0.
  - flush_o = 0; redirect_pc_o = IDLE_PC.
- Watchdog:
  - Counter (clog2(STALL_TIMEOUT+1) bits) increments each RUN cycle with stall_o ≠ 0, saturating at STALL_TIMEOUT.
  - It clears on any cycle with stall_o = 0, on an event, and in HALT.
  - stall_timeout_o = (counter == STALL_TIMEOUT) && STALL_TIMEOUT ≠ 0. It is registered, one cycle after the STALL_TIMEOUT-th stalled cycle.
- Simultaneous refill, exception and ERET: refill wins. An event with a stall request present: the event wins and the stall is dropped.

Test Plan:
- Reset: rst=1 for 2 cycles with stall_req_i=6'b111111 and exc_valid_i=1 -> outputs 0, redirect_pc_o=0x80000000, busy_o=0.
- Stall prefix: stall_req_i=6'b010000 -> stall_o=6'b011111. Then 6'b000010 -> 6'b000011. Then 6'b010100 -> 6'b011111; flush_o=0 throughout.
- Exceptions, cp0_ebase_i=0x80001000, cp0_epc_i=0x80000404:
  - exc_valid_i -> redirect 0x80001180, flush_o=6'b111110, then 1 SHADOW cycle with a second exc_valid_i ignored.
  - ERET -> 0x80000404.
  - Refill+exc together -> 0x80001000.
- Shadow length: SHADOW_CYCLES=3, one exception, stall_req_i held 6'b001000 -> busy_o high 3 cycles, stall_o=0 during them, stall_o=6'b001111 on the 4th cycle.
- Halt: halt_req_i=1 while stall_req_i=6'b000100 -> stall_o=6'b111111 same cycle, halt_ack_o=1 next cycle. exc_valid_i during HALT -> no redirect. Release halt -> RUN.
- Watchdog: STALL_TIMEOUT=4, stall_req_i constant 6'b000001 -> stall_timeout_o rises on the cycle after the 4th stalled cycle. Drop request -> falls next cycle. STALL_TIMEOUT=0 -> never asserts.
